// File: rtl/rr_sel_arbiter_4ch_if.sv
// rr_sel_arbiter_4ch_if
// Bundles the request side and select side of the 4-channel round-robin
// arbiter.
//   en        : arbitration enable. Gates new grants only; it never revokes one.
//   req[3:0]  : per-channel level requests.
//   sel[1:0]  : registered granted index. It drives the 2-to-4 decoder:
//               sel[1] -> a, sel[0] -> b.
//   sel_valid : sel carries a live grant.
//   last_sel  : index of the most recently released channel.
//   timeout   : one-cycle forced-release pulse. Exists only when
//               GRANT_TIMEOUT_EN is defined.
// Modports: master = arbiter side, slave = requester side.
interface rr_sel_arbiter_4ch_if;
  logic       en;
  logic [3:0] req;
  logic [1:0] sel;
  logic       sel_valid;
  logic [1:0] last_sel;
`ifdef GRANT_TIMEOUT_EN
  logic       timeout;
`endif

  modport master (
    input  en,
    input  req,
    output sel,
    output sel_valid,
`ifdef GRANT_TIMEOUT_EN
    output timeout,
`endif
    output last_sel
  );

  modport slave (
    output en,
    output req,
    input  sel,
    input  sel_valid,
`ifdef GRANT_TIMEOUT_EN
    input  timeout,
`endif
    input  last_sel
  );
endinterface

// File: rtl/rr_sel_arbiter_4ch.sv
// rr_sel_arbiter_4ch
// Four-channel round-robin arbiter. It produces the registered 2-bit select
// for the downstream channel-enable decoder. A grant is held until its owner
// drops req, so the decoder output stays stable for the whole transaction.
//
// Ports:
//   clk   : system clock, rising edge.
//   rst_n : asynchronous active-low reset.
//   bus   : rr_sel_arbiter_4ch_if.master, carrying en, req, sel, sel_valid,
//           last_sel and timeout.
//
// Optional feature (macro GRANT_TIMEOUT_EN):
//   An 8-bit hold counter forces a release after TIMEOUT_CYCLES grant cycles,
//   but only while another channel is waiting.
//
// state | meaning
// IDLE  | no live grant; sel keeps its last value
// GRANT | sel owned by channel sel until it drops req (or is forced off)
module rr_sel_arbiter_4ch #(
  parameter int NUM_CH         = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rr_sel_arbiter_4ch_if.master bus
);

  if (NUM_CH != 4 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_param_check
    $error("rr_sel_arbiter_4ch: illegal NUM_CH or TIMEOUT_CYCLES");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] last_q, last_d;
  logic       valid_q, valid_d;
  logic       rel_now;

`ifdef GRANT_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       force_rel;
  logic       timeout_q;
  logic       others_req;
`endif

  // Scan base+1 .. base+4 (mod 4). The base channel itself is checked last,
  // so a just-released owner wins only when it is the sole requester.
  function automatic logic [1:0] rr_pick(input logic [1:0] base, input logic [3:0] r);
    logic [1:0] idx;
    rr_pick = base;
    for (int i = 4; i >= 1; i--) begin
      idx = base + 2'(i);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    valid_d = valid_q;
    rel_now = !bus.req[sel_q];
`ifdef GRANT_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
    force_rel  = 1'b0;
    others_req = |(bus.req & ~(4'b0001 << sel_q));
`endif
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (bus.en && (|bus.req)) begin
          sel_d   = rr_pick(last_q, bus.req);
          valid_d = 1'b1;
          state_d = GRANT;
`ifdef GRANT_TIMEOUT_EN
          hold_cnt_d = '0;
`endif
        end
      end
      GRANT: begin
`ifdef GRANT_TIMEOUT_EN
        if (!rel_now) begin
          if (hold_cnt_q == HOLD_LAST) begin
            // At the limit: force a release only if someone is waiting.
            // Otherwise restart the hold window.
            if (others_req) force_rel = 1'b1;
            else            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + 8'd1;
          end
        end
        if (force_rel) rel_now = 1'b1;
`endif
        if (rel_now) begin
          last_d = sel_q;
          // Re-grant in the same edge so sel_valid shows no bubble.
          if (bus.en && (|bus.req)) begin
            sel_d = rr_pick(sel_q, bus.req);
`ifdef GRANT_TIMEOUT_EN
            hold_cnt_d = '0;
`endif
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 2'b00;
      last_q  <= 2'b11;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

`ifdef GRANT_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= force_rel;
    end
  end

  assign bus.timeout = timeout_q;
`endif

  assign bus.sel       = sel_q;
  assign bus.sel_valid = valid_q;
  assign bus.last_sel  = last_q;

endmodule

// File: tb/tb_rr_sel_arbiter_4ch.sv
module tb_rr_sel_arbiter_4ch;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rr_sel_arbiter_4ch_if bus ();

  rr_sel_arbiter_4ch #(.NUM_CH(4), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: current owner, pointer, and hold count kept as plain ints.
  int m_sel, m_last, m_cnt;
  bit m_valid, m_to;

  function automatic int rr_first(int base, logic [3:0] r);
    for (int k = 1; k <= 4; k++)
      if (r[(base + k) % 4]) return (base + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_sel = 0; m_last = 3; m_valid = 0; m_cnt = 0; m_to = 0;
  endtask

  task automatic model_step(logic e, logic [3:0] r);
    bit rel;
    m_to = 0;
    if (!m_valid) begin
      if (e && r != 0) begin
        m_sel = rr_first(m_last, r); m_valid = 1; m_cnt = 0;
      end
    end else begin
      rel = !r[m_sel];
`ifdef GRANT_TIMEOUT_EN
      if (!rel) begin
        if (m_cnt == TO - 1) begin
          if ((r & ~(4'b0001 << m_sel)) != 0) begin rel = 1; m_to = 1; end
          else m_cnt = 0;
        end else m_cnt = m_cnt + 1;
      end
`endif
      if (rel) begin
        m_last = m_sel;
        if (e && r != 0) begin m_sel = rr_first(m_last, r); m_cnt = 0; end
        else m_valid = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(bus.en, bus.req);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; bus.en = 1'b0; bus.req = 4'b0000;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if (bus.sel !== 2'b00 || bus.sel_valid !== 1'b0 || bus.last_sel !== 2'b11) begin
      n_err++;
      $display("FAIL reset: sel=%b valid=%b last=%b, required 00 0 11", bus.sel, bus.sel_valid, bus.last_sel);
    end
`ifdef GRANT_TIMEOUT_EN
    n_vec++;
    if (bus.timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b required 0", bus.timeout); end
`endif
  endtask

  task automatic test_single();
    logic [3:0] y;
    bus.en = 1'b1; bus.req = 4'b0100;
    tick();
    y = bus.sel_valid ? (4'b0001 << bus.sel) : 4'b0000;
    n_vec++;
    if (bus.sel_valid !== 1'b1 || bus.sel !== 2'b10 || y !== 4'b0100) begin
      n_err++;
      $display("FAIL single_grant: valid=%b sel=%b dec=%b, required 1 10 0100", bus.sel_valid, bus.sel, y);
    end
    bus.req = 4'b0000;
    tick();
    n_vec++;
    if (bus.sel_valid !== 1'b0 || bus.last_sel !== 2'b10) begin
      n_err++;
      $display("FAIL single_release: valid=%b last=%b, required 0 10", bus.sel_valid, bus.last_sel);
    end
  endtask

  task automatic test_rotation();
    int cur;
    do_reset();
    bus.en = 1'b1; bus.req = 4'b1111;
    tick();
    n_vec++;
    if (bus.sel !== 2'b00 || bus.sel_valid !== 1'b1) begin
      n_err++; $display("FAIL rotation_first: sel=%b valid=%b, required 00 1", bus.sel, bus.sel_valid);
    end
    cur = 0;
    for (int i = 0; i < 4; i++) begin
      bus.req = 4'b1111 & ~(4'b0001 << cur);
      tick();
      n_vec++;
      if (bus.sel !== 2'((cur + 1) % 4) || bus.sel_valid !== 1'b1) begin
        n_err++;
        $display("FAIL rotation_step%0d: sel=%0d valid=%b, required %0d 1", i, bus.sel, bus.sel_valid, (cur + 1) % 4);
      end
      cur = (cur + 1) % 4;
      bus.req = 4'b1111;
      tick();
      n_vec++;
      if (bus.sel !== 2'(cur) || bus.sel_valid !== 1'b1) begin
        n_err++;
        $display("FAIL rotation_hold%0d: sel=%0d valid=%b, required %0d 1", i, bus.sel, bus.sel_valid, cur);
      end
    end
  endtask

  task automatic test_pointer();
    do_reset();
    bus.en = 1'b1; bus.req = 4'b0010;
    tick();
    bus.req = 4'b1011;
    tick();
    n_vec++;
    if (bus.sel !== 2'b01 || bus.sel_valid !== 1'b1) begin
      n_err++; $display("FAIL pointer_hold: sel=%b valid=%b, required 01 1", bus.sel, bus.sel_valid);
    end
    bus.req = 4'b1001;
    tick();
    n_vec++;
    if (bus.sel !== 2'b11 || bus.sel_valid !== 1'b1 || bus.last_sel !== 2'b01) begin
      n_err++;
      $display("FAIL pointer_next: sel=%b valid=%b last=%b, required 11 1 01", bus.sel, bus.sel_valid, bus.last_sel);
    end
    bus.req = 4'b0000;
    tick();
  endtask

  task automatic test_enable();
    do_reset();
    bus.en = 1'b0; bus.req = 4'b0001;
    repeat (2) tick();
    n_vec++;
    if (bus.sel_valid !== 1'b0) begin n_err++; $display("FAIL en_blocked: valid=%b required 0", bus.sel_valid); end
    bus.en = 1'b1;
    tick();
    n_vec++;
    if (bus.sel !== 2'b00 || bus.sel_valid !== 1'b1) begin
      n_err++; $display("FAIL en_grant: sel=%b valid=%b, required 00 1", bus.sel, bus.sel_valid);
    end
    bus.en = 1'b0; bus.req = 4'b0011;
    repeat (2) tick();
    n_vec++;
    if (bus.sel !== 2'b00 || bus.sel_valid !== 1'b1) begin
      n_err++; $display("FAIL en_low_keep: sel=%b valid=%b, required 00 1", bus.sel, bus.sel_valid);
    end
    bus.req = 4'b0010;
    tick();
    n_vec++;
    if (bus.sel_valid !== 1'b0 || bus.last_sel !== 2'b00) begin
      n_err++; $display("FAIL en_low_release: valid=%b last=%b, required 0 00", bus.sel_valid, bus.last_sel);
    end
    bus.req = 4'b0000; bus.en = 1'b1;
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.en = 1'b1; bus.req = 4'b0100;
    tick();
    #2 rst_n = 1'b0;
    bus.req = 4'b0000;
    model_reset();
    #1;
    n_vec++;
    if (bus.sel_valid !== 1'b0 || bus.sel !== 2'b00 || bus.last_sel !== 2'b11) begin
      n_err++;
      $display("FAIL async_reset: valid=%b sel=%b last=%b, required 0 00 11", bus.sel_valid, bus.sel, bus.last_sel);
    end
    rst_n = 1'b1;
    tick();
    bus.req = 4'b0101;
    tick();
    n_vec++;
    if (bus.sel !== 2'b00 || bus.sel_valid !== 1'b1) begin
      n_err++; $display("FAIL post_reset_grant: sel=%b valid=%b, required 00 1", bus.sel, bus.sel_valid);
    end
    bus.req = 4'b0000;
    tick();
  endtask

  task automatic test_random();
    logic [3:0] r;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bus.en = (($urandom % 8) != 0);
      r = 4'($urandom);
      if (m_valid && ($urandom % 4) != 0) r[m_sel] = 1'b1;
      bus.req = r;
      tick();
      n_vec++;
      if (bus.sel !== 2'(m_sel) || bus.sel_valid !== m_valid || bus.last_sel !== 2'(m_last)) begin
        n_err++;
        $display("FAIL random%0d: sel=%0d valid=%b last=%0d, required %0d %b %0d",
                 i, bus.sel, bus.sel_valid, bus.last_sel, m_sel, m_valid, m_last);
      end
`ifdef GRANT_TIMEOUT_EN
      n_vec++;
      if (bus.timeout !== m_to) begin
        n_err++; $display("FAIL random_timeout%0d: got %b required %b", i, bus.timeout, m_to);
      end
`endif
    end
    bus.req = 4'b0000;
    tick();
  endtask

`ifdef GRANT_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    bus.en = 1'b1; bus.req = 4'b0001;
    tick();
    bus.req = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (bus.timeout !== 1'b0 || bus.sel !== 2'b00) begin
        n_err++; $display("FAIL timeout_early%0d: to=%b sel=%b, required 0 00", i, bus.timeout, bus.sel);
      end
    end
    tick();
    n_vec++;
    if (bus.timeout !== 1'b1 || bus.sel !== 2'b01 || bus.sel_valid !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_fire: to=%b sel=%b valid=%b, required 1 01 1", bus.timeout, bus.sel, bus.sel_valid);
    end
    tick();
    n_vec++;
    if (bus.timeout !== 1'b0) begin n_err++; $display("FAIL timeout_pulse: got %b required 0", bus.timeout); end
    bus.req = 4'b0001;
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      n_vec++;
      if (bus.timeout !== 1'b0 || bus.sel !== 2'b00 || bus.sel_valid !== 1'b1) begin
        n_err++;
        $display("FAIL timeout_alone%0d: to=%b sel=%b valid=%b, required 0 00 1", i, bus.timeout, bus.sel, bus.sel_valid);
      end
    end
    bus.req = 4'b0000;
    tick();
  endtask
`endif

  initial begin
    bus.en = 1'b0;
    bus.req = 4'b0000;
    model_reset();
    test_reset();
    test_single();
    test_rotation();
    test_pointer();
    test_enable();
    test_async_reset();
`ifdef GRANT_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rr_sel_arbiter_4ch.md
Name: rr_sel_arbiter_4ch

Overview:
Four-channel round-robin arbiter. Produces the registered 2-bit select that drives the downstream 2-to-4 decoder (sel[1] -> decoder input a, sel[0] -> decoder input b). The decoder's one-hot outputs become the per-channel enables. A grant is held until the owning requester drops its request, so the decoder output is stable for the whole transaction.

Parameters:
NUM_CH, 4, number of channels; fixed at 4 to match the 2-bit select, any other value is illegal.
TIMEOUT_CYCLES, 16, maximum hold cycles when GRANT_TIMEOUT_EN is defined; legal range 2..255.

Ports:
clk  input  1  single system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
en  input  1  arbitration enable; when low, no new grant is issued and the current grant continues.
req  input  4  per-channel request, level, held until the channel is finished.
sel  output  2  registered index of the granted channel; feeds the decoder.
sel_valid  output  1  sel is a live grant.
last_sel  output  2  index of the most recently released channel (the round-robin pointer base).
timeout  output  1  one-cycle pulse on forced release; present only with GRANT_TIMEOUT_EN.

Behaviour:
- Reset (rst_n low, asynchronous):
  - sel=2'b00, sel_valid=0, last_sel=2'b11 (so ch0 has first priority), timeout=0.
  - State goes to IDLE and the hold counter clears.
  - Reset asserted mid-grant drops sel_valid immediately, without waiting for a clock edge.
- States: IDLE, GRANT.
- IDLE:
  - If en=1 and req!=0, the winner is the first set req bit scanning last_sel+1, last_sel+2, last_sel+3, last_sel+4 (mod 4).
  - sel<=winner and sel_valid<=1 at that edge (1-cycle latency from req to sel_valid), then go to GRANT.
  - If en=0 or req=0, stay in IDLE with sel_valid=0 and sel holding its last value.
- GRANT:
  - sel is frozen while req[sel]=1; other req changes are ignored.
  - When req[sel]=0 at an edge: last_sel<=sel.
    - If en=1 and another req bit is set, re-arbitrate in the same edge using the updated pointer (base = old sel). sel takes the new winner, sel_valid stays 1 (no bubble), and the state stays GRANT.
    - Otherwise sel_valid<=0 and go to IDLE.
  - en=0 during GRANT does not revoke the grant; it only blocks the re-grant at release.
- A released channel that re-asserts req in the same cycle is the lowest priority for the next scan. It wins only if it is the sole requester.
- All 4 bits of req set continuously give the rotation 0,1,2,3,0,... as each owner cycles req low for one clock.
- req is sampled synchronously; async sources are synchronised upstream. X on req is a bench error.
- sel never changes while sel_valid=1 except at a release or re-grant edge.

Optional Feature:
Macro: GRANT_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter increments each GRANT cycle and clears on every new grant.
  - When the counter reaches TIMEOUT_CYCLES-1 and another channel is requesting, the grant is forcibly released: last_sel<=sel, re-arbitration proceeds as for a normal release, and timeout pulses high for 1 cycle.
  - The starved owner keeps requesting and competes normally.
  - If no other channel is requesting, the counter clears and the grant is held (no pulse).
- Undefined: there is no counter and no timeout port, and a grant is held indefinitely.

Test Plan:
1. Reset then req=4'b0100 -> sel_valid=1 and sel=2'b10 one cycle later; decoder y2=1 only; sel_valid=0 one cycle after req drops; last_sel=2'b10.
2. req=4'b1111 held, owner drops its req bit for 1 clock each time -> grant sequence sel=0,1,2,3,0 with sel_valid continuously 1 (no bubble).
3. Grant ch1 active, req=4'b1011, ch1 drops -> next sel=2'b11 (ch3 beats ch0 per the pointer).
4. en=0 with req=4'b0001 -> sel_valid stays 0; en raised -> sel=0, sel_valid=1 next cycle; en dropped mid-grant -> grant kept; release -> IDLE.
5. rst_n pulsed low between clock edges during a grant to ch2 -> sel_valid=0 and sel=0 immediately; after release, req=4'b0101 -> ch0 granted.
6. (GRANT_TIMEOUT_EN, TIMEOUT_CYCLES=4) ch0 holds, ch1 requesting -> after 4 grant cycles timeout=1 for 1 cycle and sel=1; ch0 alone holding -> no timeout.
